elevator_fsm: RTL
=================

# elevator_fsm

Upstream sequencer of the two-floor FPGA elevator. It synchronises the floor call buttons, latches pending requests and runs the car state machine. It produces the `state` / `counting_value` pair consumed by the motor controller: the motor runs while travelling with a nonzero count and stops at zero. It also drives door and request indicators.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per timing tick (≥2); prescaler width is `$clog2(TICK_DIV)`.
- `TRAVEL_TICKS`, 3'd5: travel countdown load value, 1..7.
- `DOOR_TICKS`, 3'd3: door dwell countdown load value, 1..7.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `btn_floor1`  in  1  raw call button, floor 1 (asynchronous to `clk`)
- `btn_floor2`  in  1  raw call button, floor 2 (asynchronous to `clk`)
- `state`  out  3  0 idle, 1 floor1, 2 floor2, 3 going_to_1, 4 going_to_2
- `counting_value`  out  3  active countdown (travel or dwell); 0 in idle
- `cur_floor`  out  1  0 = floor 1, 1 = floor 2; last floor reached
- `door_open`  out  1  high in floor1/floor2
- `req_led`  out  2  pending requests, bit0 = floor 1, bit1 = floor 2

## Operation
- Buttons: each passes a 2-flop synchroniser and a rising-edge detector, giving a one-cycle `req_edge`.
- Pending requests: `req_edge[X]` sets `pend[X]`. This is not done in two cases:
  - state is going_to_X;
  - state is floorX, where the edge reloads `counting_value` with `DOOR_TICKS` instead.
- `pend[X]` clears on entry to floorX. `req_led = pend`.
- Prescaler: counts 0..`TICK_DIV-1`, and `tick` is high while it equals `TICK_DIV-1`. It clears to 0 on every state change and on a dwell reload.
- idle (`counting_value` = 0):
  - `pend[cur_floor]` set → floor(cur_floor), load `DOOR_TICKS`.
  - Otherwise, `pend[other]` set → going_to_other, load `TRAVEL_TICKS`.
  - With both set, the current floor wins.
- going_to_X:
  - On `tick` with `counting_value` > 0: decrement.
  - On `tick` with `counting_value` == 0: → floorX, `cur_floor` ← X, load `DOOR_TICKS`.
- floorX:
  - On `tick` with `counting_value` > 0: decrement.
  - On `tick` with `counting_value` == 0: → idle, `counting_value` ← 0.
- States 5–7 are illegal: go to idle next cycle with `counting_value` 0.
- All outputs are registered; `door_open` is derived from the next state and registered.
- Reset values: `state` 0, `counting_value` 0, `cur_floor` 0, `door_open` 0, `req_led` 00, synchronisers 0, prescaler 0. After reset the car is assumed parked at floor 1.
- Reset asserted mid-operation forces these values immediately, without a clock; pending requests are lost.

## Timing
- Button high first sampled at edge N → `req_led` bit set at N+2 → state leaves idle at N+3 (when idle).
- Travel, entered at edge E:
  - `counting_value` decrements at E+k·`TICK_DIV`.
  - It reaches 0 at E+`TRAVEL_TICKS`·`TICK_DIV`.
  - floorX is entered at E+(`TRAVEL_TICKS`+1)·`TICK_DIV`.
  - The motor sees the count of 0 for one full tick before the state changes.
- Dwell lasts (`DOOR_TICKS`+1)·`TICK_DIV` cycles from entry or last reload.
- Button held high produces exactly one request; re-request requires release of at least 1 cycle.
- An edge arriving in the same cycle as the transition into floorX is evaluated against the new state: no latch, dwell reload.

## Test plan
Bench parameters: `TICK_DIV`=4, `TRAVEL_TICKS`=3, `DOOR_TICKS`=2.
1. Assert `rst`=0 with no clock running → `state`=0, `counting_value`=0, `cur_floor`=0, `door_open`=0, `req_led`=00. Release → all outputs hold.
2. From idle at floor 1, `btn_floor2` first sampled at edge N, then:
   - `req_led`=10 at N+2;
   - `state`=4, `counting_value`=3 at N+3;
   - count 2/1/0 at N+7/N+11/N+15;
   - `state`=2, `counting_value`=2, `door_open`=1, `cur_floor`=1, `req_led`=00 at N+19;
   - `state`=0 at N+31.
3. From idle at floor 1, `btn_floor1` at N → `state`=1 at N+3 with no travel state visited → `state`=0 at N+15.
4. Both buttons rise in the same cycle from idle at floor 1 → floor1 dwell first, `req_led`=10 during dwell → going_to_2 on the cycle after dwell returns to idle.
5. In floor2 with `counting_value`=0, press `btn_floor2` → `counting_value` reloads to 2, dwell extended 12 cycles, `req_led` stays 00. A `btn_floor1` press during going_to_2 → `req_led`=01, served after the floor2 dwell.
6. Assert `rst` low mid-travel (`state`=4, `counting_value`=2) → reset values appear asynchronously. After release, a pending floor-2 request from before reset is not served.

Source files
------------

// File: rtl/elevator_fsm.sv
// Two-floor elevator sequencer: button synchronisers, pending-request latches and the car FSM
// producing the state/counting_value pair consumed by the motor controller.
module elevator_fsm #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter logic [2:0]  TRAVEL_TICKS = 3'd5,
  parameter logic [2:0]  DOOR_TICKS   = 3'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_floor1,
  input  logic       btn_floor2,
  output logic [2:0] state,
  output logic [2:0] counting_value,
  output logic       cur_floor,
  output logic       door_open,
  output logic [1:0] req_led
);

  localparam int unsigned    PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FLOOR1     = 3'd1,
    S_FLOOR2     = 3'd2,
    S_GOING_TO_1 = 3'd3,
    S_GOING_TO_2 = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic          cur_floor_q, cur_floor_d;
  logic          door_open_q, door_open_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    sync1_q, sync2_q, prev_q;
  logic [PW-1:0] presc_q, presc_d;

  logic          tick;
  logic [1:0]    req_edge;
  logic          reload;
  logic          here_idx;
  logic          arrive1, arrive2;
  logic          block1, block2;

  // Next-state, countdown, request latch and prescaler logic
  always_comb begin
    tick        = (presc_q == PRESC_MAX);
    req_edge    = sync2_q & ~prev_q;
    here_idx    = (state_q == S_FLOOR2);
    state_d     = state_q;
    count_d     = count_q;
    cur_floor_d = cur_floor_q;
    reload      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Current floor wins when both requests are pending
        if (pend_q[cur_floor_q]) begin
          state_d = cur_floor_q ? S_FLOOR2 : S_FLOOR1;
          count_d = DOOR_TICKS;
        end else if (pend_q[~cur_floor_q]) begin
          state_d = cur_floor_q ? S_GOING_TO_1 : S_GOING_TO_2;
          count_d = TRAVEL_TICKS;
        end else begin
          state_d = S_IDLE;
          count_d = 3'd0;
        end
      end
      S_GOING_TO_1, S_GOING_TO_2: begin
        if (tick) begin
          if (count_q != 3'd0) begin
            count_d = count_q - 3'd1;
          end else begin
            state_d     = (state_q == S_GOING_TO_1) ? S_FLOOR1 : S_FLOOR2;
            cur_floor_d = (state_q == S_GOING_TO_2);
            count_d     = DOOR_TICKS;
          end
        end else begin
          count_d = count_q;
        end
      end
      S_FLOOR1, S_FLOOR2: begin
        // A call for the floor the car is parked at holds the door open longer
        if (req_edge[here_idx]) begin
          reload  = 1'b1;
          count_d = DOOR_TICKS;
        end else if (tick) begin
          if (count_q != 3'd0) begin
            count_d = count_q - 3'd1;
          end else begin
            state_d = S_IDLE;
            count_d = 3'd0;
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 3'd0;
      end
    endcase

    arrive1 = (state_d == S_FLOOR1);
    arrive2 = (state_d == S_FLOOR2);
    block1  = (state_q == S_GOING_TO_1) || (state_q == S_FLOOR1) || arrive1;
    block2  = (state_q == S_GOING_TO_2) || (state_q == S_FLOOR2) || arrive2;
    pend_d[0] = arrive1 ? 1'b0 : (pend_q[0] | (req_edge[0] & ~block1));
    pend_d[1] = arrive2 ? 1'b0 : (pend_q[1] | (req_edge[1] & ~block2));

    door_open_d = arrive1 | arrive2;

    if ((state_d != state_q) || reload) begin
      presc_d = {PW{1'b0}};
    end else if (tick) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // All state, including synchronisers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= 3'd0;
      cur_floor_q <= 1'b0;
      door_open_q <= 1'b0;
      pend_q      <= 2'b00;
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      prev_q      <= 2'b00;
      presc_q     <= {PW{1'b0}};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cur_floor_q <= cur_floor_d;
      door_open_q <= door_open_d;
      pend_q      <= pend_d;
      sync1_q     <= {btn_floor2, btn_floor1};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      presc_q     <= presc_d;
    end
  end

  assign state          = state_q;
  assign counting_value = count_q;
  assign cur_floor      = cur_floor_q;
  assign door_open      = door_open_q;
  assign req_led        = pend_q;

endmodule
